// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: button conditioning, cursor, fire/clear strobes and game phase.
// Optional AUTO_REPEAT_EN: held direction buttons re-trigger a move every REPEAT_CYCLES in PLAY.
module battleship_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES   = 3,
  parameter int unsigned GRID_N          = 10,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_u,
  input  logic                         btn_d,
  input  logic                         btn_l,
  input  logic                         btn_r,
  input  logic                         btn_c,
  input  logic [2*GRID_N*GRID_N-1:0]   cell_status_flat,
  input  logic [4:0]                   turns_left,
  input  logic [2:0]                   ships_remaining,
  output logic [3:0]                   sprite_row,
  output logic [3:0]                   sprite_col,
  output logic                         fire,
  output logic                         board_clear,
  output logic [2:0]                   game_phase,
  output logic [6:0]                   shots_fired,
  output logic [1:0]                   last_result
);

  localparam int unsigned NB    = 5;
  localparam int unsigned B_U   = 0;
  localparam int unsigned B_D   = 1;
  localparam int unsigned B_L   = 2;
  localparam int unsigned B_R   = 3;
  localparam int unsigned B_C   = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SEL_W = $clog2(2 * GRID_N * GRID_N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  if (DEBOUNCE_CYCLES < 2 || SETTLE_CYCLES < 2 || GRID_N < 2 || GRID_N > 16 ||
      REPEAT_CYCLES < 1) begin : g_param_check
    $error("battleship_game_ctrl: parameter out of range");
  end

  logic [NB-1:0]            btn_raw;
  logic [NB-1:0]            sync1_q, sync2_q;
  logic [NB-1:0]            acc_q, acc_d;
  logic [NB-1:0]            press_q, press_d;
  logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]               dir_evt_c;

  logic [2:0]       state_q, state_d;
  logic [3:0]       row_q, row_d, col_q, col_d;
  logic [3:0]       frow_q, frow_d, fcol_q, fcol_d;
  logic [6:0]       shots_q, shots_d;
  logic [1:0]       last_q, last_d;
  logic             fire_q, fire_d, clr_q, clr_d;
  logic [SET_W-1:0] settle_q, settle_d;

  logic [SEL_W-1:0] cur_sel_c, fire_sel_c;
  logic [1:0]       cur_cell_c, fired_cell_c;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  // Debounce: count consecutive synchronized samples that differ from the accepted level.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        acc_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d = acc_d & ~acc_q;
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [3:0][RPT_W-1:0] rpt_q, rpt_d;
  logic [3:0]            rpt_evt_c;

  // Repeat timers run only while a direction is held in PLAY.
  always_comb begin
    rpt_d     = rpt_q;
    rpt_evt_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (state_q == S_PLAY && acc_q[i]) begin
        if (rpt_q[i] == RPT_W'(REPEAT_CYCLES - 1)) begin
          rpt_d[i]     = '0;
          rpt_evt_c[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end else begin
        rpt_d[i] = '0;
      end
    end
    dir_evt_c = press_q[3:0] | rpt_evt_c;
  end

  always_ff @(posedge clk) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign dir_evt_c = press_q[3:0];
`endif

  assign cur_sel_c    = SEL_W'(row_q) * SEL_W'(2 * GRID_N) + SEL_W'(col_q) * SEL_W'(2);
  assign fire_sel_c   = SEL_W'(frow_q) * SEL_W'(2 * GRID_N) + SEL_W'(fcol_q) * SEL_W'(2);
  assign cur_cell_c   = cell_status_flat[cur_sel_c +: 2];
  assign fired_cell_c = cell_status_flat[fire_sel_c +: 2];

  // Game sequencer; strobes are registered so they line up with the phase they belong to.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    frow_d   = frow_q;
    fcol_d   = fcol_q;
    shots_d  = shots_q;
    last_d   = last_q;
    settle_d = settle_q;
    fire_d   = 1'b0;
    clr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q[B_C]) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        shots_d = '0;
        last_d  = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (ships_remaining == 3'd0) begin
          state_d = S_WIN;
        end else if (turns_left == 5'd0) begin
          state_d = S_LOSE;
        end else if (press_q[B_C]) begin
          if (cur_cell_c == 2'b00) begin
            fire_d   = 1'b1;
            shots_d  = (shots_q == 7'd127) ? shots_q : shots_q + 7'd1;
            frow_d   = row_q;
            fcol_d   = col_q;
            settle_d = SET_W'(SETTLE_CYCLES);
            state_d  = S_WAIT;
          end
        end else begin
          if (dir_evt_c[B_U] && !dir_evt_c[B_D])
            row_d = (row_q == 4'd0) ? 4'(GRID_N - 1) : row_q - 4'd1;
          else if (dir_evt_c[B_D] && !dir_evt_c[B_U])
            row_d = (row_q == 4'(GRID_N - 1)) ? 4'd0 : row_q + 4'd1;
          if (dir_evt_c[B_L] && !dir_evt_c[B_R])
            col_d = (col_q == 4'd0) ? 4'(GRID_N - 1) : col_q - 4'd1;
          else if (dir_evt_c[B_R] && !dir_evt_c[B_L])
            col_d = (col_q == 4'(GRID_N - 1)) ? 4'd0 : col_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (settle_q <= SET_W'(1)) begin
          settle_d = '0;
          last_d   = fired_cell_c;
          state_d  = S_PLAY;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (press_q[B_C]) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
    clr_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      frow_q   <= '0;
      fcol_q   <= '0;
      shots_q  <= '0;
      last_q   <= '0;
      settle_q <= '0;
      fire_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      frow_q   <= frow_d;
      fcol_q   <= fcol_d;
      shots_q  <= shots_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      fire_q   <= fire_d;
      clr_q    <= clr_d;
    end
  end

  assign sprite_row  = row_q;
  assign sprite_col  = col_q;
  assign fire        = fire_q;
  assign board_clear = clr_q;
  assign game_phase  = state_q;
  assign shots_fired = shots_q;
  assign last_result = last_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Bench for battleship_game_ctrl: scripted vector table, multi-cycle corner cases and a random
// button walk checked against a cursor/board reference model.
module tb_battleship_game_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned G  = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_u, btn_d, btn_l, btn_r, btn_c;
  logic [199:0] cell_status_flat;
  logic [4:0]   turns_left;
  logic [2:0]   ships_remaining;
  logic [3:0]   sprite_row, sprite_col;
  logic         fire, board_clear;
  logic [2:0]   game_phase;
  logic [6:0]   shots_fired;
  logic [1:0]   last_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  battleship_game_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SETTLE_CYCLES  (ST),
    .GRID_N         (G)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_u           (btn_u),
    .btn_d           (btn_d),
    .btn_l           (btn_l),
    .btn_r           (btn_r),
    .btn_c           (btn_c),
    .cell_status_flat(cell_status_flat),
    .turns_left      (turns_left),
    .ships_remaining (ships_remaining),
    .sprite_row      (sprite_row),
    .sprite_col      (sprite_col),
    .fire            (fire),
    .board_clear     (board_clear),
    .game_phase      (game_phase),
    .shots_fired     (shots_fired),
    .last_result     (last_result)
  );

  // Board stand-in: fired cells become hit or miss according to a hidden ship map.
  logic [1:0]  cells [100];
  logic [99:0] ship_map;
  logic        force_lose, force_win;

  always @(posedge clk) begin
    if (reset || board_clear) begin
      for (int i = 0; i < 100; i++) cells[i] <= 2'b00;
    end else if (fire) begin
      cells[int'(sprite_row) * 10 + int'(sprite_col)] <=
        ship_map[int'(sprite_row) * 10 + int'(sprite_col)] ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    cell_status_flat = '0;
    for (int i = 0; i < 100; i++) cell_status_flat[2*i +: 2] = cells[i];
  end

  assign turns_left      = force_lose ? 5'd0 : 5'd20;
  assign ships_remaining = force_win  ? 3'd0 : 3'd3;

  // Strobe monitor
  int fire_cnt = 0, fire_run = 0, fire_max = 0;
  int clr_cnt = 0, clr_run = 0, clr_max = 0;
  int wait_run = 0, wait_len = 0, strobe_err = 0;

  always @(negedge clk) begin
    if (fire === 1'b1) begin
      fire_cnt++; fire_run++;
      if (fire_run > fire_max) fire_max = fire_run;
    end else fire_run = 0;
    if (board_clear === 1'b1) begin
      clr_cnt++; clr_run++;
      if (clr_run > clr_max) clr_max = clr_run;
    end else clr_run = 0;
    if (game_phase == 3'd3) wait_run++;
    else begin
      if (wait_run != 0) wait_len = wait_run;
      wait_run = 0;
    end
    if (fire === 1'b1 && board_clear === 1'b1) strobe_err++;
    if (fire === 1'b1 && game_phase != 3'd3) strobe_err++;
    if (board_clear === 1'b1 && game_phase != 3'd1) strobe_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mask bit order {c, r, l, d, u}; held long enough to be accepted, then released and settled
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = m;
    repeat (DB + 4) @(negedge clk);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    repeat (DB + ST + 8) @(negedge clk);
  endtask

  task automatic check_play(input string tag, input int r, input int c, input int s, input int l);
    check({tag, " row"}, 32'(sprite_row), 32'(r));
    check({tag, " col"}, 32'(sprite_col), 32'(c));
    check({tag, " shots"}, 32'(shots_fired), 32'(s));
    check({tag, " last"}, 32'(last_result), 32'(l));
  endtask

  typedef struct {
    logic [4:0] btn;
    int         row, col, shots, last, fires;
  } vec_t;

  localparam logic [4:0] PU = 5'b00001, PD = 5'b00010, PL = 5'b00100, PR = 5'b01000, PC = 5'b10000;

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [12];
    logic [127:0] rnd;
    int           f0, c0, exp_last;
    int           m_row, m_col, m_shots, m_last, exp_f, idx;
    logic [1:0]   m_cells [100];
    logic [4:0]   m;
    logic         seen;

    vecs[0]  = '{PL,           0, 9, 0, 0, 0};
    vecs[1]  = '{PU,           9, 9, 0, 0, 0};
    vecs[2]  = '{PR,           9, 0, 0, 0, 0};
    vecs[3]  = '{PD,           0, 0, 0, 0, 0};
    vecs[4]  = '{PD,           1, 0, 0, 0, 0};
    vecs[5]  = '{PR,           1, 1, 0, 0, 0};
    vecs[6]  = '{PC,           1, 1, 1, 2, 1};
    vecs[7]  = '{PC,           1, 1, 1, 2, 0};
    vecs[8]  = '{PR,           1, 2, 1, 2, 0};
    vecs[9]  = '{PC | PR,      1, 2, 2, 2, 1};
    vecs[10] = '{PU | PD | PL, 1, 1, 2, 2, 0};
    vecs[11] = '{PU|PD|PL|PR,  1, 1, 2, 2, 0};

    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    ship_map = rnd[99:0];
    ship_map[11] = 1'b1;
    ship_map[12] = 1'b1;
    force_lose = 1'b0;
    force_win  = 1'b0;
    reset = 1'b1;
    {btn_c, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    repeat (3) @(negedge clk);

    check("reset phase", 32'(game_phase), 32'd0);
    check("reset fire", 32'(fire), 32'd0);
    check("reset clear", 32'(board_clear), 32'd0);
    check_play("reset", 0, 0, 0, 0);
    reset = 1'b0;

    press(PL);
    check("idle dir phase", 32'(game_phase), 32'd0);
    check("idle dir col", 32'(sprite_col), 32'd0);

    c0 = clr_cnt;
    press(PC);
    check("start clear pulses", 32'(clr_cnt - c0), 32'd1);
    check("start clear width", 32'(clr_max), 32'd1);
    check("start phase", 32'(game_phase), 32'd2);
    check_play("start", 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      f0 = fire_cnt;
      press(vecs[i].btn);
      check($sformatf("vec%0d", i), 32'(game_phase), 32'd2);
      check_play($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].shots, vecs[i].last);
      check($sformatf("vec%0d fires", i), 32'(fire_cnt - f0), 32'(vecs[i].fires));
    end
    check("fire width", 32'(fire_max), 32'd1);
    check("wait length", 32'(wait_len), 32'(ST));

    // 2-cycle glitch must not be accepted
    @(negedge clk); btn_d = 1'b1;
    repeat (2) @(negedge clk); btn_d = 1'b0;
    repeat (DB + 12) @(negedge clk);
    check_play("glitch", 1, 1, 2, 2);

    // direction press landing while WAIT is active is dropped
    press(PR);
    press(PR);
    f0 = fire_cnt;
    exp_last = ship_map[13] ? 2 : 1;
    @(negedge clk); btn_c = 1'b1;
    @(negedge clk); btn_r = 1'b1;
    repeat (DB + 4) @(negedge clk);
    {btn_c, btn_r} = 2'b0;
    repeat (DB + ST + 8) @(negedge clk);
    check("wait drop fires", 32'(fire_cnt - f0), 32'd1);
    check_play("wait drop", 1, 3, 3, exp_last);

    // LOSE, restart, WIN
    force_lose = 1'b1;
    repeat (2) @(negedge clk);
    check("lose phase", 32'(game_phase), 32'd5);
    press(PL);
    check("lose frozen col", 32'(sprite_col), 32'd3);
    force_lose = 1'b0;
    c0 = clr_cnt;
    press(PC);
    check("restart clear pulses", 32'(clr_cnt - c0), 32'd1);
    check("restart phase", 32'(game_phase), 32'd2);
    check_play("restart", 0, 0, 0, 0);
    force_win = 1'b1;
    repeat (2) @(negedge clk);
    check("win phase", 32'(game_phase), 32'd4);
    press(PR);
    check("win frozen col", 32'(sprite_col), 32'd0);
    force_win = 1'b0;
    press(PC);
    check("newgame phase", 32'(game_phase), 32'd2);

    // random walk against the reference model
    m_row = 0; m_col = 0; m_shots = 0; m_last = 0;
    for (int i = 0; i < 100; i++) m_cells[i] = 2'b00;
    for (int it = 0; it < 40; it++) begin
      m = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) m[4] = 1'b0;
      exp_f = 0;
      if (m[4]) begin
        idx = m_row * 10 + m_col;
        if (m_cells[idx] == 2'b00) begin
          m_cells[idx] = ship_map[idx] ? 2'b10 : 2'b01;
          m_last  = int'(m_cells[idx]);
          m_shots = (m_shots < 127) ? m_shots + 1 : 127;
          exp_f   = 1;
        end
      end else begin
        m_row = (m_row + G + int'(m[1]) - int'(m[0])) % G;
        m_col = (m_col + G + int'(m[3]) - int'(m[2])) % G;
      end
      f0 = fire_cnt;
      press(m);
      check_play($sformatf("rnd%0d", it), m_row, m_col, m_shots, m_last);
      check($sformatf("rnd%0d fires", it), 32'(fire_cnt - f0), 32'(exp_f));
    end

    // reset while WAIT: find an untouched cell, fire, then reset mid-settle
    for (int k = 0; k < 100; k++) begin
      if (m_cells[m_row * 10 + m_col] == 2'b00) break;
      if (k % 10 == 9) begin press(PD); m_row = (m_row + 1) % G; end
      else begin press(PR); m_col = (m_col + 1) % G; end
    end
    check("seek untouched", 32'(m_cells[m_row * 10 + m_col]), 32'd0);
    seen = 1'b0;
    @(negedge clk); btn_c = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (game_phase == 3'd3) begin seen = 1'b1; break; end
    end
    check("reached wait", 32'(seen), 32'd1);
    reset = 1'b1;
    btn_c = 1'b0;
    @(negedge clk);
    check("midreset phase", 32'(game_phase), 32'd0);
    check("midreset fire", 32'(fire), 32'd0);
    check("midreset clear", 32'(board_clear), 32'd0);
    check_play("midreset", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    f0 = fire_cnt;
    repeat (20) @(negedge clk);
    check("post reset fires", 32'(fire_cnt - f0), 32'd0);
    check("post reset phase", 32'(game_phase), 32'd0);
    check("strobe rules", 32'(strobe_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
